// File: rtl/bp_update_ctrl_pkg.sv
// Shared definitions for the branch predictor update controller:
// default widths, PT counter encodings, controller states and the
// 2-bit saturating counter update.
package bp_update_ctrl_pkg;

    localparam int unsigned PtIdxBitsDef  = 8;
    localparam int unsigned BtbIdxBitsDef = 4;
    localparam int unsigned TagBitsDef    = 26;
    localparam int unsigned BhrBitsDef    = 8;
    localparam int unsigned DBitsDef      = 32;

    typedef enum logic [1:0] {
        PtSnt = 2'd0,
        PtWnt = 2'd1,
        PtWt  = 2'd2,
        PtSt  = 2'd3
    } pt_cnt_e;

    // Tables come out of the init sweep as weakly not-taken.
    localparam logic [1:0] PtInit = PtWnt;

    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } bp_state_e;

    // Saturating 2-bit counter step towards the resolved direction.
    function automatic logic [1:0] pt_next(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == PtSt) ? PtSt : cnt + 2'd1;
        end
        return (cnt == PtSnt) ? PtSnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Two-entry valid/ready FIFO holding resolved-branch updates.
// Ready depends only on the occupancy register, never on the read side.
module bp_upd_fifo #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wvalid_i,
    output logic             wready_o,
    input  logic [Width-1:0] wdata_i,
    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [2];
    logic             wptr_q, rptr_q;
    logic [1:0]       cnt_q, cnt_d;
    logic             push, pop;

    assign wready_o = (cnt_q != 2'd2);
    assign rvalid_o = (cnt_q != 2'd0);
    assign rdata_o  = mem_q[rptr_q];
    assign push     = wvalid_i && wready_o;
    assign pop      = rready_i && rvalid_o;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) cnt_d = cnt_q + 2'd1;
        if (pop && !push) cnt_d = cnt_q - 2'd1;
    end

    // Storage and pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= ~wptr_q;
            end
            if (pop) rptr_q <= ~rptr_q;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// Single writer of the branch predictor state (PT, BTB, BHR). Sweeps both
// tables after reset with fetch stalled, then drains queued AGEX updates
// one per cycle into the table write ports.
module bp_update_ctrl
    import bp_update_ctrl_pkg::*;
#(
    parameter int unsigned PT_IDX_BITS  = PtIdxBitsDef,
    parameter int unsigned BTB_IDX_BITS = BtbIdxBitsDef,
    parameter int unsigned TAG_BITS     = TagBitsDef,
    parameter int unsigned BHR_BITS     = BhrBitsDef,
    parameter int unsigned DBITS        = DBitsDef
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    upd_valid_i,
    output logic                    upd_ready_o,
    input  logic                    upd_is_cond_i,
    input  logic                    upd_taken_i,
    input  logic [PT_IDX_BITS-1:0]  upd_pt_idx_i,
    input  logic [1:0]              upd_pt_old_i,
    input  logic [BTB_IDX_BITS-1:0] upd_btb_idx_i,
    input  logic [TAG_BITS-1:0]     upd_tag_i,
    input  logic [DBITS-1:0]        upd_target_i,
    output logic                    fe_stall_o,
    output logic                    pt_we_o,
    output logic [PT_IDX_BITS-1:0]  pt_waddr_o,
    output logic [1:0]              pt_wdata_o,
    output logic                    btb_we_o,
    output logic [BTB_IDX_BITS-1:0] btb_waddr_o,
    output logic                    btb_wvalid_o,
    output logic [TAG_BITS-1:0]     btb_wtag_o,
    output logic [DBITS-1:0]        btb_wtarget_o,
    output logic [BHR_BITS-1:0]     bhr_o
);

    localparam int unsigned SwBits = (PT_IDX_BITS > BTB_IDX_BITS) ? PT_IDX_BITS : BTB_IDX_BITS;
    localparam int unsigned EntW   = 2 + PT_IDX_BITS + 2 + BTB_IDX_BITS + TAG_BITS + DBITS;
    localparam logic [SwBits-1:0] SwLast = '1;

    bp_state_e              state_q;
    logic [SwBits-1:0]      sweep_q;
    logic [BHR_BITS-1:0]    bhr_q;
    logic                   fwd_valid_q;
    logic [PT_IDX_BITS-1:0] fwd_idx_q;
    logic [1:0]             fwd_cnt_q;

    logic                    run;
    logic                    fifo_wready, head_valid;
    logic [EntW-1:0]         head;
    logic                    h_is_cond, h_taken;
    logic [PT_IDX_BITS-1:0]  h_pt_idx;
    logic [1:0]              h_pt_old, pt_base, pt_new;
    logic [BTB_IDX_BITS-1:0] h_btb_idx;
    logic [TAG_BITS-1:0]     h_tag;
    logic [DBITS-1:0]        h_target;
    logic                    pt_in_range, btb_in_range;

    assign run = (state_q == StRun);

    bp_upd_fifo #(
        .Width (EntW)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wvalid_i (upd_valid_i && run),
        .wready_o (fifo_wready),
        .wdata_i  ({upd_is_cond_i, upd_taken_i, upd_pt_idx_i, upd_pt_old_i,
                    upd_btb_idx_i, upd_tag_i, upd_target_i}),
        .rvalid_o (head_valid),
        .rready_i (run),
        .rdata_o  (head)
    );

    assign {h_is_cond, h_taken, h_pt_idx, h_pt_old, h_btb_idx, h_tag, h_target} = head;

    // The PT read at fetch may predate the previous drained write to the same index.
    assign pt_base = (fwd_valid_q && (fwd_idx_q == h_pt_idx)) ? fwd_cnt_q : h_pt_old;
    assign pt_new  = pt_next(pt_base, h_taken);

    assign pt_in_range  = ((sweep_q >> PT_IDX_BITS) == '0);
    assign btb_in_range = ((sweep_q >> BTB_IDX_BITS) == '0);

    assign upd_ready_o = run && fifo_wready;
    assign fe_stall_o  = !run;
    assign bhr_o       = bhr_q;

    // Write ports: sweep writes during init, queue head writes during run.
    always_comb begin
        pt_we_o       = 1'b0;
        pt_waddr_o    = '0;
        pt_wdata_o    = '0;
        btb_we_o      = 1'b0;
        btb_waddr_o   = '0;
        btb_wvalid_o  = 1'b0;
        btb_wtag_o    = '0;
        btb_wtarget_o = '0;
        if (!run) begin
            if (pt_in_range) begin
                pt_we_o    = 1'b1;
                pt_waddr_o = sweep_q[PT_IDX_BITS-1:0];
                pt_wdata_o = PtInit;
            end
            if (btb_in_range) begin
                btb_we_o    = 1'b1;
                btb_waddr_o = sweep_q[BTB_IDX_BITS-1:0];
            end
        end else if (head_valid) begin
            if (h_is_cond) begin
                pt_we_o    = 1'b1;
                pt_waddr_o = h_pt_idx;
                pt_wdata_o = pt_new;
            end
            if (h_taken) begin
                btb_we_o      = 1'b1;
                btb_waddr_o   = h_btb_idx;
                btb_wvalid_o  = 1'b1;
                btb_wtag_o    = h_tag;
                btb_wtarget_o = h_target;
            end
        end
        // No table writes while reset is held.
        if (!rst_ni) begin
            pt_we_o  = 1'b0;
            btb_we_o = 1'b0;
        end
    end

    // Controller FSM: init sweep, then history and forward register upkeep.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StInit;
            sweep_q     <= '0;
            bhr_q       <= '0;
            fwd_valid_q <= 1'b0;
            fwd_idx_q   <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            case (state_q)
                StInit: begin
                    sweep_q <= sweep_q + 1'b1;
                    if (sweep_q == SwLast) state_q <= StRun;
                end
                StRun: begin
                    if (head_valid) begin
                        if (h_is_cond) begin
                            bhr_q       <= {bhr_q[BHR_BITS-2:0], h_taken};
                            fwd_valid_q <= 1'b1;
                            fwd_idx_q   <= h_pt_idx;
                            fwd_cnt_q   <= pt_new;
                        end else begin
                            fwd_valid_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Scoreboard bench for bp_update_ctrl: stimulus pushes expected table writes
// computed from a behavioural predictor model; a monitor pops and compares.
module tb_bp_update_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upd_valid = 1'b0, upd_ready;
    logic        upd_is_cond = 1'b0, upd_taken = 1'b0;
    logic [7:0]  upd_pt_idx = '0;
    logic [1:0]  upd_pt_old = '0;
    logic [3:0]  upd_btb_idx = '0;
    logic [25:0] upd_tag = '0;
    logic [31:0] upd_target = '0;
    logic        fe_stall, pt_we, btb_we, btb_wvalid;
    logic [7:0]  pt_waddr, bhr;
    logic [1:0]  pt_wdata;
    logic [3:0]  btb_waddr;
    logic [25:0] btb_wtag;
    logic [31:0] btb_wtarget;

    always #5 clk = ~clk;

    bp_update_ctrl #(
        .PT_IDX_BITS  (8),
        .BTB_IDX_BITS (4),
        .TAG_BITS     (26),
        .BHR_BITS     (8),
        .DBITS        (32)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .upd_valid_i   (upd_valid),
        .upd_ready_o   (upd_ready),
        .upd_is_cond_i (upd_is_cond),
        .upd_taken_i   (upd_taken),
        .upd_pt_idx_i  (upd_pt_idx),
        .upd_pt_old_i  (upd_pt_old),
        .upd_btb_idx_i (upd_btb_idx),
        .upd_tag_i     (upd_tag),
        .upd_target_i  (upd_target),
        .fe_stall_o    (fe_stall),
        .pt_we_o       (pt_we),
        .pt_waddr_o    (pt_waddr),
        .pt_wdata_o    (pt_wdata),
        .btb_we_o      (btb_we),
        .btb_waddr_o   (btb_waddr),
        .btb_wvalid_o  (btb_wvalid),
        .btb_wtag_o    (btb_wtag),
        .btb_wtarget_o (btb_wtarget),
        .bhr_o         (bhr)
    );

    typedef struct packed {
        logic        pt_we;
        logic [7:0]  pt_addr;
        logic [1:0]  pt_data;
        logic        btb_we;
        logic [3:0]  btb_addr;
        logic [25:0] tag;
        logic [31:0] tgt;
        logic [7:0]  bhr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;

    // Model state: global history plus the last PT value written and its index.
    logic [7:0] m_bhr = '0;
    logic       m_last_v = 1'b0;
    logic [7:0] m_last_idx = '0;
    int         m_last_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_bhr = '0;
        m_last_v = 1'b0;
        sb.delete();
    endtask

    // Expected effect of one accepted update, in drain order.
    task automatic model_accept(input logic c, input logic t, input logic [7:0] pidx,
                                input logic [1:0] old, input logic [3:0] bidx,
                                input logic [25:0] tag, input logic [31:0] tgt);
        exp_t e;
        int   base, nv;
        e = '0;
        e.bhr = m_bhr;
        if (c) begin
            base = (m_last_v && m_last_idx == pidx) ? m_last_cnt : int'(old);
            nv = t ? ((base == 3) ? 3 : base + 1) : ((base == 0) ? 0 : base - 1);
            e.pt_we = 1'b1;
            e.pt_addr = pidx;
            e.pt_data = nv[1:0];
            m_last_v = 1'b1;
            m_last_idx = pidx;
            m_last_cnt = nv;
            m_bhr = {m_bhr[6:0], t};
        end else begin
            m_last_v = 1'b0;
        end
        if (t) begin
            e.btb_we = 1'b1;
            e.btb_addr = bidx;
            e.tag = tag;
            e.tgt = tgt;
        end
        if (e.pt_we || e.btb_we) sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic c, input logic t, input logic [7:0] pidx,
                        input logic [1:0] old, input logic [3:0] bidx,
                        input logic [25:0] tag, input logic [31:0] tgt);
        upd_valid = 1'b1;
        upd_is_cond = c;
        upd_taken = t;
        upd_pt_idx = pidx;
        upd_pt_old = old;
        upd_btb_idx = bidx;
        upd_tag = tag;
        upd_target = tgt;
        for (int w = 0; w < 20; w++) begin
            if (upd_ready) begin
                model_accept(c, t, pidx, old, bidx, tag, tgt);
                @(negedge clk);
                upd_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        check("send_timeout", 1, 0);
        upd_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
             8'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             4'($urandom_range(0, 15)), 26'($urandom), $urandom);
    endtask

    // Release reset and verify the whole init sweep plus the switch to run.
    task automatic sweep_and_check();
        logic [7:0] iv;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            #1;
            iv = i[7:0];
            check("sweep_pt", {fe_stall, upd_ready, pt_we, pt_waddr, pt_wdata},
                  {1'b1, 1'b0, 1'b1, iv, 2'b01});
            if (i < 16)
                check("sweep_btb", {btb_we, btb_waddr, btb_wvalid}, {1'b1, iv[3:0], 1'b0});
            else
                check("sweep_btb", {btb_we}, {1'b0});
            @(negedge clk);
        end
        #1;
        check("run_entry", {fe_stall, upd_ready, pt_we, btb_we}, {1'b0, 1'b1, 1'b0, 1'b0});
    endtask

    task automatic wait_drain();
        for (int w = 0; w < 50 && sb.size() != 0; w++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("drain_empty", sb.size(), 0);
    endtask

    // Monitor: every observed table write must match the oldest expected one.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && (pt_we || btb_we)) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {pt_we, pt_waddr, btb_we, btb_waddr}, 0);
            end else begin
                e = sb.pop_front();
                check("pt_write", {pt_we, pt_we ? {pt_waddr, pt_wdata} : 10'd0},
                      {e.pt_we, e.pt_addr, e.pt_data});
                check("btb_write",
                      {btb_we, btb_we ? {btb_waddr, btb_wvalid, btb_wtag, btb_wtarget} : 63'd0},
                      {e.btb_we, e.btb_addr, e.btb_we, e.tag, e.tgt});
                check("bhr_at_drain", bhr, e.bhr);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_state", {fe_stall, upd_ready, pt_we, btb_we, bhr},
              {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        sweep_and_check();
        mon_en = 1'b1;
        @(negedge clk);

        // Single conditional taken: bhr moves two edges after acceptance.
        send(1'b1, 1'b1, 8'h12, 2'b01, 4'd3, 26'h0abcdef, 32'h100);
        check("bhr_before", bhr, 8'h00);
        @(negedge clk);
        check("bhr_after", bhr, 8'h01);
        repeat (2) @(negedge clk);

        // Saturation both ways, then back-to-back same index (forwarded).
        send(1'b1, 1'b1, 8'h20, 2'b11, 4'd4, 26'h1, 32'h200);
        send(1'b1, 1'b0, 8'h21, 2'b00, 4'd5, 26'h2, 32'h300);
        @(negedge clk);
        send(1'b1, 1'b1, 8'h05, 2'b01, 4'd6, 26'h3, 32'h400);
        send(1'b1, 1'b1, 8'h05, 2'b01, 4'd6, 26'h3, 32'h400);
        wait_drain();
        check("bhr_directed", bhr, 8'h1b);

        // Jump: BTB only, leaves history alone.
        send(1'b0, 1'b1, 8'h05, 2'b01, 4'd9, 26'h4, 32'h500);
        wait_drain();
        check("bhr_jump", bhr, 8'h1b);

        // Sustained one-per-cycle stream keeps ready high.
        for (int k = 0; k < 4; k++) begin
            check("ready_burst", upd_ready, 1'b1);
            send_rand();
        end
        wait_drain();

        // Randomised traffic with idle gaps.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) < 7) send_rand();
            else @(negedge clk);
        end
        wait_drain();
        check("bhr_random", bhr, m_bhr);

        // Reset in run with an update queued: it must vanish and the sweep restart.
        @(negedge clk);
        upd_valid = 1'b1;
        upd_is_cond = 1'b1;
        upd_taken = 1'b1;
        upd_pt_idx = 8'h33;
        upd_btb_idx = 4'd7;
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        upd_valid = 1'b0;
        #1;
        check("midrun_reset", {fe_stall, upd_ready, pt_we, btb_we, bhr},
              {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        model_reset();
        repeat (2) @(negedge clk);
        sweep_and_check();
        mon_en = 1'b1;
        @(negedge clk);
        send(1'b1, 1'b1, 8'h07, 2'b10, 4'd1, 26'h5, 32'h600);
        wait_drain();
        check("bhr_post_reset", bhr, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
